// File: rtl/ethernet_udp_receive_if.sv
// Payload stream and per-frame status bundle of the MII UDP receiver.
// master: receiver drives the stream; slave: user logic consumes it.
interface ethernet_udp_receive_if;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic [15:0] payload_len;
  logic [47:0] src_mac;
  logic [31:0] src_ip;
  logic [15:0] src_port;
  logic        frame_done;
  logic        frame_ok;

  modport master (
    output out_data, out_valid, out_last, payload_len,
    output src_mac, src_ip, src_port, frame_done, frame_ok
  );

  modport slave (
    input out_data, out_valid, out_last, payload_len,
    input src_mac, src_ip, src_port, frame_done, frame_ok
  );
endinterface

// File: rtl/ethernet_udp_receive.sv
// MII receiver: preamble/SFD detect, Ethernet II/IPv4/UDP filter, payload
// stream out, CRC-32 check. Ports: clk/rstn, MII rx_*, local_* filter, udp bundle.
module ethernet_udp_receive #(
  parameter int MAX_PAYLOAD_BYTES    = 1472,
  parameter bit ACCEPT_BROADCAST     = 1'b1,
  parameter int MIN_PREAMBLE_NIBBLES = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [3:0]  rx_d,
  input  logic [47:0] local_mac,
  input  logic [31:0] local_ip,
  input  logic [15:0] local_port,
  ethernet_udp_receive_if.master udp
);

  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
  localparam logic [16:0] LEN_MAX = 17'(MAX_PAYLOAD_BYTES + 8);
  localparam logic [7:0]  PRE_MIN = 8'(MIN_PREAMBLE_NIBBLES);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, HEADER, PAYLOAD, TRAILER, DROP
  } state_t;

  state_t state, state_nxt;

  logic [7:0]  pre_cnt;
  logic        phase;
  logic [3:0]  lo_nib;
  logic [5:0]  byte_cnt;
  logic [15:0] pay_cnt;
  logic [2:0]  trl_cnt;
  logic [31:0] crc;
  logic        err;
  logic [39:0] sh;
  logic [47:0] sh_mac;
  logic [31:0] sh_ip;
  logic [15:0] sh_port;
  logic [15:0] sh_len;

  logic [7:0]  data_q;
  logic        valid_q;
  logic        last_q;
  logic [15:0] plen;
  logic [47:0] smac;
  logic [31:0] sip;
  logic [15:0] sport;
  logic        done_q;
  logic        ok_q;

  logic [7:0]  byte_now;
  logic        in_frame;
  logic        byte_done;
  logic [31:0] crc_nxt;
  logic [15:0] udp_len;
  logic [47:0] dst_mac;
  logic        hdr_bad;
  logic        pay_last;

  function automatic logic [31:0] crc_step(
    input logic [31:0] c,
    input logic [7:0]  b
  );
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign byte_now  = {rx_d, lo_nib};
  assign in_frame  = (state == HEADER) || (state == PAYLOAD) ||
                     (state == TRAILER);
  assign byte_done = in_frame && rx_dv && phase;
  assign crc_nxt   = crc_step(crc, byte_now);
  assign udp_len   = {sh[7:0], byte_now};
  assign dst_mac   = {sh, byte_now};
  assign pay_last  = (pay_cnt == plen - 16'd1);

  // Header fields are checked on the byte that completes them, using the
  // shift register for the earlier bytes of the field.
  always_comb begin
    hdr_bad = 1'b0;
    unique case (byte_cnt)
      6'd5:  hdr_bad = !((dst_mac == local_mac) ||
                         (ACCEPT_BROADCAST && (dst_mac == '1)));
      6'd13: hdr_bad = (udp_len != 16'h0800);
      6'd14: hdr_bad = (byte_now != 8'h45);
      6'd23: hdr_bad = (byte_now != 8'd17);
      6'd33: hdr_bad = ({sh[23:0], byte_now} != local_ip);
      6'd37: hdr_bad = (udp_len != local_port);
      6'd39: hdr_bad = (udp_len < 16'd8) || ({1'b0, udp_len} > LEN_MAX);
      default: hdr_bad = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (rx_dv && rx_d == 4'h5) state_nxt = PREAMBLE;
      PREAMBLE:
        if (!rx_dv) state_nxt = DROP;
        else if (rx_d == 4'h5) state_nxt = PREAMBLE;
        else if (rx_d == 4'hD && pre_cnt >= PRE_MIN) state_nxt = HEADER;
        else state_nxt = DROP;
      HEADER:
        if (!rx_dv) state_nxt = IDLE;
        else if (byte_done && hdr_bad) state_nxt = DROP;
        else if (byte_done && byte_cnt == 6'd41)
          state_nxt = (sh_len == 16'd0) ? TRAILER : PAYLOAD;
      PAYLOAD:
        if (!rx_dv) state_nxt = IDLE;
        else if (byte_done && pay_last) state_nxt = TRAILER;
      TRAILER:
        if (!rx_dv) state_nxt = IDLE;
      DROP:
        if (!rx_dv) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pre_cnt <= '0;
      phase   <= 1'b0;
      lo_nib  <= '0;
      byte_cnt <= '0;
      pay_cnt <= '0;
      trl_cnt <= '0;
      crc     <= '0;
      err     <= 1'b0;
      sh      <= '0;
      sh_mac  <= '0;
      sh_ip   <= '0;
      sh_port <= '0;
      sh_len  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      plen    <= '0;
      smac    <= '0;
      sip     <= '0;
      sport   <= '0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;

      if (state != IDLE && rx_er) err <= 1'b1;

      if (in_frame && rx_dv) begin
        phase <= ~phase;
        if (!phase) lo_nib <= rx_d;
        if (byte_done) crc <= crc_nxt;
      end

      unique case (state)
        IDLE: begin
          pre_cnt <= 8'd1;
          err     <= 1'b0;
        end
        PREAMBLE: begin
          if (rx_d == 4'h5 && pre_cnt != 8'hFF) pre_cnt <= pre_cnt + 8'd1;
          // Byte phase and CRC restart at the SFD.
          phase    <= 1'b0;
          byte_cnt <= '0;
          crc      <= '1;
        end
        HEADER: if (byte_done) begin
          sh       <= {sh[31:0], byte_now};
          byte_cnt <= byte_cnt + 6'd1;
          if (byte_cnt == 6'd11) sh_mac  <= dst_mac;
          if (byte_cnt == 6'd29) sh_ip   <= {sh[23:0], byte_now};
          if (byte_cnt == 6'd35) sh_port <= udp_len;
          if (byte_cnt == 6'd39) sh_len  <= udp_len - 16'd8;
          if (byte_cnt == 6'd41) begin
            smac    <= sh_mac;
            sip     <= sh_ip;
            sport   <= sh_port;
            plen    <= sh_len;
            pay_cnt <= '0;
            trl_cnt <= '0;
          end
        end
        PAYLOAD: begin
          if (!rx_dv) begin
            done_q <= 1'b1;
          end else if (byte_done) begin
            data_q  <= byte_now;
            valid_q <= 1'b1;
            last_q  <= pay_last;
            pay_cnt <= pay_cnt + 16'd1;
          end
        end
        TRAILER: begin
          if (!rx_dv) begin
            done_q <= 1'b1;
            ok_q   <= (crc == RESIDUE) && !err && !phase &&
                      (trl_cnt >= 3'd4);
          end else if (byte_done && trl_cnt != 3'd4) begin
            trl_cnt <= trl_cnt + 3'd1;
          end
        end
        DROP: ;
        default: ;
      endcase
    end
  end

  assign udp.out_data    = data_q;
  assign udp.out_valid   = valid_q;
  assign udp.out_last    = last_q;
  assign udp.payload_len = plen;
  assign udp.src_mac     = smac;
  assign udp.src_ip      = sip;
  assign udp.src_port    = sport;
  assign udp.frame_done  = done_q;
  assign udp.frame_ok    = ok_q;

endmodule

// File: tb/tb_ethernet_udp_receive.sv
// Scoreboard bench for ethernet_udp_receive: directed MII frames, expected
// payload bytes and frame status queued at issue, popped by a monitor.
module tb_ethernet_udp_receive;

  localparam logic [47:0] LOCAL_MAC  = 48'h020000000001;
  localparam logic [31:0] LOCAL_IP   = 32'h0A000002;
  localparam logic [15:0] LOCAL_PORT = 16'd5000;
  localparam logic [47:0] SRC_MAC    = 48'h0200000000AA;
  localparam logic [31:0] SRC_IP     = 32'h0A000001;

  typedef struct {
    bit         is_done;
    logic [7:0] data;
    logic       last;
    logic       ok;
  } ev_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rx_dv = 1'b0;
  logic       rx_er = 1'b0;
  logic [3:0] rx_d = 4'h0;

  ethernet_udp_receive_if u_if ();
  ethernet_udp_receive_if u_if2 ();

  ethernet_udp_receive dut (
    .clk(clk), .rstn(rstn),
    .rx_dv(rx_dv), .rx_er(rx_er), .rx_d(rx_d),
    .local_mac(LOCAL_MAC), .local_ip(LOCAL_IP),
    .local_port(LOCAL_PORT),
    .udp(u_if)
  );

  ethernet_udp_receive #(.ACCEPT_BROADCAST(1'b0)) dut_nobc (
    .clk(clk), .rstn(rstn),
    .rx_dv(rx_dv), .rx_er(rx_er), .rx_d(rx_d),
    .local_mac(LOCAL_MAC), .local_ip(LOCAL_IP),
    .local_port(LOCAL_PORT),
    .udp(u_if2)
  );

  always #20 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int done2 = 0;
  ev_t exp_q[$];
  logic [7:0] frm[$];
  logic [7:0] pay [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] want);
    checks++;
    if (act === want) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, want);
  endtask

  function automatic logic [31:0] crc_upd(logic [31:0] c, logic [7:0] b);
    c = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  task automatic push_byte(input logic [7:0] d, input logic l);
    ev_t e;
    e.is_done = 1'b0; e.data = d; e.last = l; e.ok = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input logic ok);
    ev_t e;
    e.is_done = 1'b1; e.data = 8'h00; e.last = 1'b0; e.ok = ok;
    exp_q.push_back(e);
  endtask

  task automatic build(input logic [47:0] dmac, input logic [15:0] dport,
                       input logic [15:0] sport, input int npay);
    logic [31:0] c;
    logic [15:0] ulen;
    logic [15:0] tlen;
    frm.delete();
    ulen = 16'(8 + npay);
    tlen = 16'(28 + npay);
    for (int i = 5; i >= 0; i--) frm.push_back(dmac[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) frm.push_back(SRC_MAC[i*8 +: 8]);
    frm.push_back(8'h08); frm.push_back(8'h00);
    frm.push_back(8'h45); frm.push_back(8'h00);
    frm.push_back(tlen[15:8]); frm.push_back(tlen[7:0]);
    frm.push_back(8'h00); frm.push_back(8'h00);
    frm.push_back(8'h40); frm.push_back(8'h00);
    frm.push_back(8'h40); frm.push_back(8'h11);
    frm.push_back(8'h00); frm.push_back(8'h00);
    for (int i = 3; i >= 0; i--) frm.push_back(SRC_IP[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) frm.push_back(LOCAL_IP[i*8 +: 8]);
    frm.push_back(sport[15:8]); frm.push_back(sport[7:0]);
    frm.push_back(dport[15:8]); frm.push_back(dport[7:0]);
    frm.push_back(ulen[15:8]); frm.push_back(ulen[7:0]);
    frm.push_back(8'h00); frm.push_back(8'h00);
    for (int i = 0; i < npay; i++) frm.push_back(pay[i]);
    for (int i = 0; i < 18; i++) frm.push_back(8'h00);
    c = 32'hFFFFFFFF;
    foreach (frm[i]) c = crc_upd(c, frm[i]);
    c = ~c;
    frm.push_back(c[7:0]);   frm.push_back(c[15:8]);
    frm.push_back(c[23:16]); frm.push_back(c[31:24]);
  endtask

  task automatic nib(input logic dv, input logic [3:0] d, input logic rn);
    @(posedge clk);
    #1;
    rx_dv = dv;
    rx_d  = d;
    rstn  = rn;
  endtask

  task automatic send(input int nsend, input int rst_at, input int gap);
    for (int i = 0; i < 15; i++) nib(1'b1, 4'h5, 1'b1);
    nib(1'b1, 4'hD, 1'b1);
    for (int i = 0; i < nsend; i++) begin
      nib(1'b1, frm[i][3:0], (i == rst_at) ? 1'b0 : 1'b1);
      nib(1'b1, frm[i][7:4], 1'b1);
    end
    for (int i = 0; i < gap; i++) nib(1'b0, 4'h0, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    repeat (4) @(posedge clk);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (u_if.out_valid) begin
      chk("byte_pending", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_data", 64'(u_if.out_data),
            e.is_done ? 64'h1FF : 64'(e.data));
        chk("out_last", 64'(u_if.out_last), 64'(e.last));
      end
    end
    if (u_if.frame_done) begin
      chk("done_pending", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("frame_ok", 64'(u_if.frame_ok),
            e.is_done ? 64'(e.ok) : 64'h2);
      end
    end
    if (u_if2.frame_done) done2++;
  end

  initial begin
    repeat (40000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d2;

    repeat (4) nib(1'b0, 4'h0, 1'b0);
    #10;
    chk("rst_out_valid", 64'(u_if.out_valid), 64'd0);
    chk("rst_frame_done", 64'(u_if.frame_done), 64'd0);
    chk("rst_src_mac", 64'(u_if.src_mac), 64'd0);
    chk("rst_payload_len", 64'(u_if.payload_len), 64'd0);
    repeat (2) nib(1'b0, 4'h0, 1'b1);

    // Good unicast frame.
    d2 = done2;
    build(LOCAL_MAC, LOCAL_PORT, 16'h1234, 4);
    push_byte(8'hDE, 0); push_byte(8'hAD, 0);
    push_byte(8'hBE, 0); push_byte(8'hEF, 1);
    push_done(1'b1);
    send(frm.size(), -1, 4);
    drain();
    chk("good_src_mac", 64'(u_if.src_mac), 64'(SRC_MAC));
    chk("good_src_ip", 64'(u_if.src_ip), 64'(SRC_IP));
    chk("good_src_port", 64'(u_if.src_port), 64'h1234);
    chk("good_payload_len", 64'(u_if.payload_len), 64'd4);
    chk("nobc_unicast_done", 64'(done2 - d2), 64'd1);

    // Wrong destination port: silently filtered.
    build(LOCAL_MAC, 16'd5001, 16'h9999, 4);
    send(frm.size(), -1, 4);
    drain();
    chk("port_src_port_held", 64'(u_if.src_port), 64'h1234);
    chk("port_len_held", 64'(u_if.payload_len), 64'd4);

    // Corrupted FCS.
    build(LOCAL_MAC, LOCAL_PORT, 16'h1234, 4);
    frm[frm.size() - 1] = frm[frm.size() - 1] ^ 8'h01;
    push_byte(8'hDE, 0); push_byte(8'hAD, 0);
    push_byte(8'hBE, 0); push_byte(8'hEF, 1);
    push_done(1'b0);
    send(frm.size(), -1, 4);
    drain();

    // rx_dv drops after the second payload byte.
    build(LOCAL_MAC, LOCAL_PORT, 16'h1234, 4);
    push_byte(8'hDE, 0); push_byte(8'hAD, 0);
    push_done(1'b0);
    send(44, -1, 4);
    drain();

    // Broadcast, zero-length payload.
    d2 = done2;
    build(48'hFFFFFFFFFFFF, LOCAL_PORT, 16'h0BCA, 0);
    push_done(1'b1);
    send(frm.size(), -1, 4);
    drain();
    chk("bc_payload_len", 64'(u_if.payload_len), 64'd0);
    chk("bc_src_port", 64'(u_if.src_port), 64'h0BCA);
    chk("nobc_bc_dropped", 64'(done2 - d2), 64'd0);

    // Reset mid-payload aborts the frame without a status pulse.
    build(LOCAL_MAC, LOCAL_PORT, 16'h4321, 4);
    push_byte(8'hDE, 0); push_byte(8'hAD, 0);
    send(frm.size(), 44, 4);
    drain();
    chk("rst_mid_src_port", 64'(u_if.src_port), 64'd0);
    chk("rst_mid_len", 64'(u_if.payload_len), 64'd0);

    // Two good frames separated by a single idle cycle.
    build(LOCAL_MAC, LOCAL_PORT, 16'h1234, 4);
    push_byte(8'hDE, 0); push_byte(8'hAD, 0);
    push_byte(8'hBE, 0); push_byte(8'hEF, 1);
    push_done(1'b1);
    send(frm.size(), -1, 1);
    build(LOCAL_MAC, LOCAL_PORT, 16'h5555, 4);
    push_byte(8'hDE, 0); push_byte(8'hAD, 0);
    push_byte(8'hBE, 0); push_byte(8'hEF, 1);
    push_done(1'b1);
    send(frm.size(), -1, 4);
    drain();
    chk("b2b_src_port", 64'(u_if.src_port), 64'h5555);
    chk("b2b_src_mac", 64'(u_if.src_mac), 64'(SRC_MAC));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ethernet_udp_receive.md
Name: ethernet_udp_receive

Overview:
- MII receive-side counterpart of the UDP transmit path. It assembles PHY nibbles into bytes and detects preamble/SFD.
- Parses the Ethernet II, IPv4 and UDP headers, filters on the local MAC/IP/port, and streams the UDP payload bytes out.
- Checks the FCS and reports a per-frame status pulse.
- Sits between the PHY receive pins (clk = PHY RX clock, 25 MHz, one nibble per cycle) and user logic.

Parameters:
MAX_PAYLOAD_BYTES, 1472, largest accepted UDP payload; larger frames are dropped.
ACCEPT_BROADCAST, 1, when 1, dest MAC FF:FF:FF:FF:FF:FF also matches.
MIN_PREAMBLE_NIBBLES, 4, minimum count of 0x5 nibbles required before the SFD nibble 0xD.

Ports:
clk  in  1  PHY receive clock; all logic on rising edge
rstn  in  1  synchronous active-low reset
rx_dv  in  1  MII receive data valid
rx_er  in  1  MII receive error
rx_d  in  4  MII receive nibble, low nibble of each byte first
local_mac  in  48  own MAC, byte 0 in bits [47:40]
local_ip  in  32  own IPv4 address
local_port  in  16  own UDP port
out_data  out  8  payload byte
out_valid  out  1  out_data valid; no backpressure
out_last  out  1  with out_valid, marks final payload byte
payload_len  out  16  UDP length minus 8, valid from first out_valid until next match
src_mac  out  48  sender MAC of last matched frame
src_ip  out  32  sender IP of last matched frame
src_port  out  16  sender UDP port of last matched frame
frame_done  out  1  one-cycle pulse at end of each matched frame
frame_ok  out  1  valid with frame_done; 1 means FCS good, no rx_er, complete frame

Behaviour:
- Reset when rstn=0 at a clk edge: state=IDLE; all outputs 0; counters and CRC cleared. A reset mid-frame aborts silently with no frame_done.
- States:
  - IDLE: rx_dv=1 and rx_d=5 -> PREAMBLE.
  - PREAMBLE: counts 0x5 nibbles.
    - rx_d=D with count>=MIN_PREAMBLE_NIBBLES -> HEADER; byte phase aligns here.
    - Any other nibble, or rx_dv=0 -> DROP.
  - HEADER: bytes 0..41 after the SFD are checked as they complete. Any mismatch -> DROP. After byte 41 -> PAYLOAD, or TRAILER if payload_len=0.
    - Dest MAC must equal local_mac (or broadcast, if enabled).
    - Ethertype must be 0x0800.
    - IP byte0=0x45; protocol (IP byte 9)=17; IP dest must equal local_ip.
    - UDP dest port must equal local_port.
    - UDP length must satisfy 8 <= length <= MAX_PAYLOAD_BYTES+8.
    - src_mac, src_ip, src_port and payload_len load only on entry to PAYLOAD/TRAILER; they hold otherwise.
  - PAYLOAD: emits each byte; after payload_len bytes -> TRAILER.
  - TRAILER: consumes padding and FCS until rx_dv=0.
  - DROP: waits for rx_dv=0 -> IDLE. No outputs, no frame_done.
- Byte assembly: nibble k even = bits [3:0], k odd = bits [7:4]. A byte completes on the odd nibble; out_valid is asserted the following cycle (latency 1), so it occurs at most every other cycle.
- out_last=1 exactly on payload byte payload_len-1.
- CRC: reflected CRC-32, poly 0xEDB88320, init 0xFFFFFFFF, over every byte from dest MAC through FCS inclusive. The frame is good if the residue is 0xDEBB20E3.
- End of frame: when rx_dv falls in PAYLOAD or TRAILER, frame_done pulses the next cycle. frame_ok=1 only when all of the following hold:
  - state was TRAILER;
  - residue good;
  - no rx_er during the frame;
  - even nibble count;
  - at least 4 bytes received after the payload.
- rx_dv falling in PAYLOAD: no out_last is emitted; frame_done=1, frame_ok=0.
- rx_er=1 in any non-IDLE state: sets a sticky error for the frame; parsing continues.
- rx_dv=0 in HEADER -> IDLE; no frame_done.
- Back-to-back frames: one rx_dv=0 cycle is sufficient to return to IDLE.

Test Plan:
- Good frame to MAC 02:00:00:00:00:01, IP 10.0.0.2, port 5000, UDP length 12, payload DE AD BE EF, correct FCS, 18 pad bytes -> out_data DE,AD,BE,EF on alternating cycles; out_last on EF; payload_len=4; src fields loaded; frame_done=1, frame_ok=1.
- Same frame with dest port 5001 -> no out_valid, no frame_done, src fields unchanged.
- Same frame with last FCS byte XOR 0x01 -> four payload bytes are emitted, then frame_done=1, frame_ok=0.
- rx_dv dropped after the second payload byte -> bytes DE,AD only; no out_last; frame_done=1, frame_ok=0.
- Broadcast dest MAC, payload_len 0, with ACCEPT_BROADCAST=1 -> no out_valid; frame_done=1, frame_ok=1. With ACCEPT_BROADCAST=0 -> silent drop.
- rstn=0 for one cycle mid-payload, then a good frame -> the first frame yields no frame_done; the second is delivered correctly with frame_ok=1.
